// File: rtl/data_cache_if.sv
// Bus bundle for data_cache: core-side load/store request port plus the
// word-wide external memory port. The cache is the slave of this bundle; the
// core and the memory model together form the master side.
//
// Handshakes:
//   core side   - en is a one-cycle strobe that samples we/addr/wd; completion
//                 is the falling edge of stall, at which point rd is valid.
//   memory side - mem_en/mem_we/mem_addr/mem_wd are held stable until a cycle
//                 with mem_en & mem_ready; that cycle completes one word, and
//                 mem_rd is taken in that same cycle for reads.
interface data_cache_if;
  logic        en;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        stall;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        mem_ready;
  logic [31:0] mem_rd;

  modport master (
    output en, we, addr, wd, mem_ready, mem_rd,
    input  rd, stall, mem_en, mem_we, mem_addr, mem_wd
  );

  modport slave (
    input  en, we, addr, wd, mem_ready, mem_rd,
    output rd, stall, mem_en, mem_we, mem_addr, mem_wd
  );
endinterface

// File: rtl/data_cache.sv
// data_cache: direct-mapped write-back data cache with a one-deep pending
// request slot. Misses write back a dirty victim, then refill the line word by
// word and re-run the lookup.
// Optional feature macro: DCACHE_WRITE_ALLOCATE_EN. When defined, store misses
// allocate (refill then merge). When undefined, store misses become a single
// write-through (WTHRU) and the line is left untouched.
module data_cache #(
  parameter int INDEX_W  = 6,
  parameter int OFFSET_W = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  data_cache_if.slave       bus,
  output logic [2:0]        dbg_state
);

  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;
  localparam int TAG_W = 32 - INDEX_W - OFFSET_W;

`ifdef DCACHE_WRITE_ALLOCATE_EN
  localparam bit WRITE_ALLOC = 1'b1;
`else
  localparam bit WRITE_ALLOC = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    WB     = 3'd2,
    FILL   = 3'd3,
    WTHRU  = 3'd4
  } state_t;

  state_t              state_q, state_d;

  // Request being serviced and the one-deep pending slot behind it.
  logic                req_we;
  logic [31:0]         req_addr, req_wd;
  logic                pend_valid, pend_we;
  logic [31:0]         pend_addr, pend_wd;

  logic [OFFSET_W-1:0] cnt_q;
  logic [31:0]         rd_q;

  logic [LINES-1:0]    valid_q, dirty_q;
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [31:0]         data_q [LINES*WORDS];

  logic [OFFSET_W-1:0] req_off;
  logic [INDEX_W-1:0]  req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic                hit, handshake, last_word;
  logic                go_idle, load_pend, load_new, capture;

  assign req_off   = req_addr[OFFSET_W-1:0];
  assign req_idx   = req_addr[OFFSET_W +: INDEX_W];
  assign req_tag   = req_addr[31 -: TAG_W];
  assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign handshake = bus.mem_en && bus.mem_ready;
  assign last_word = (cnt_q == {OFFSET_W{1'b1}});

  // A pending request is promoted straight into LOOKUP when the current one
  // finishes; the cycle-after case covers an en arriving in the finishing cycle.
  assign load_pend = pend_valid && ((state_q == IDLE) || go_idle);
  assign load_new  = (state_q == IDLE) && !pend_valid && bus.en;
  assign capture   = bus.en && (state_q != IDLE) && !pend_valid;

  assign bus.stall = bus.en | (state_q != IDLE) | pend_valid;
  assign bus.rd    = rd_q;
  assign dbg_state = state_q;

  // Next-state decode and memory-port drive; outputs depend only on state and
  // the word counter, so they stay stable while mem_ready is low.
  always_comb begin
    state_d      = state_q;
    go_idle      = 1'b0;
    bus.mem_en   = 1'b0;
    bus.mem_we   = 1'b0;
    bus.mem_addr = '0;
    bus.mem_wd   = '0;
    case (state_q)
      IDLE: begin
        if (pend_valid || bus.en) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (hit)                                          go_idle = 1'b1;
        else if (req_we && !WRITE_ALLOC)                  state_d = WTHRU;
        else if (valid_q[req_idx] && dirty_q[req_idx])    state_d = WB;
        else                                              state_d = FILL;
      end
      WB: begin
        bus.mem_en   = 1'b1;
        bus.mem_we   = 1'b1;
        bus.mem_addr = {tag_q[req_idx], req_idx, cnt_q};
        bus.mem_wd   = data_q[{req_idx, cnt_q}];
        if (handshake && last_word) state_d = FILL;
      end
      FILL: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = {req_tag, req_idx, cnt_q};
        if (handshake && last_word) state_d = LOOKUP;
      end
      WTHRU: begin
        bus.mem_en   = 1'b1;
        bus.mem_we   = 1'b1;
        bus.mem_addr = req_addr;
        bus.mem_wd   = req_wd;
        if (handshake) go_idle = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (go_idle) state_d = pend_valid ? LOOKUP : IDLE;
  end

  // State, request/pending registers, word counter and load-data register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      req_we     <= 1'b0;
      req_addr   <= '0;
      req_wd     <= '0;
      pend_valid <= 1'b0;
      pend_we    <= 1'b0;
      pend_addr  <= '0;
      pend_wd    <= '0;
      cnt_q      <= '0;
      rd_q       <= '0;
    end else begin
      state_q <= state_d;
      if (load_new) begin
        req_we   <= bus.we;
        req_addr <= bus.addr;
        req_wd   <= bus.wd;
      end else if (load_pend) begin
        req_we   <= pend_we;
        req_addr <= pend_addr;
        req_wd   <= pend_wd;
      end
      if (capture) begin
        pend_valid <= 1'b1;
        pend_we    <= bus.we;
        pend_addr  <= bus.addr;
        pend_wd    <= bus.wd;
      end else if (load_pend) begin
        pend_valid <= 1'b0;
      end
      if (handshake && ((state_q == WB) || (state_q == FILL))) cnt_q <= cnt_q + 1'b1;
      if ((state_q == LOOKUP) && hit && !req_we) rd_q <= data_q[{req_idx, req_off}];
    end
  end

  // Line status bits: dirty on store hit, clean after write-back, valid after refill.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if ((state_q == LOOKUP) && hit && req_we) dirty_q[req_idx] <= 1'b1;
      if ((state_q == WB) && handshake && last_word) dirty_q[req_idx] <= 1'b0;
      if ((state_q == FILL) && handshake && last_word) begin
        valid_q[req_idx] <= 1'b1;
        dirty_q[req_idx] <= 1'b0;
      end
    end
  end

  // Tag and data arrays: store-hit merge and refill writes.
  always_ff @(posedge clock) begin
    if ((state_q == LOOKUP) && hit && req_we) data_q[{req_idx, req_off}] <= req_wd;
    if ((state_q == FILL) && handshake) begin
      data_q[{req_idx, cnt_q}] <= bus.mem_rd;
      if (last_word) tag_q[req_idx] <= req_tag;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Testbench for data_cache: directed scenarios followed by randomized
// load/store traffic, checked against a flat-memory reference model plus a
// per-line hit/miss/dirty model that predicts stall duration.
module tb_data_cache;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [2:0] dbg_state;

  data_cache_if bus ();

  data_cache dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock / reset block
  always #5 clock = ~clock;

`ifdef DCACHE_WRITE_ALLOCATE_EN
  localparam bit ALLOC = 1'b1;
`else
  localparam bit ALLOC = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
  } xfer_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];
  xfer_t       log_q[$];
  int          wait_cfg   = 0;
  int          wait_total = 0;

  logic [31:0] backing   [logic [31:0]];
  logic [31:0] model_mem [logic [31:0]];
  logic        m_valid [64];
  logic        m_dirty [64];
  logic [23:0] m_tag   [64];
  logic [31:0] last_rd;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a + 32'h90;
  endfunction

  function automatic logic [31:0] back_rd(input logic [31:0] a);
    return backing.exists(a) ? backing[a] : dflt(a);
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : dflt(a);
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return m_valid[a[7:2]] && (m_tag[a[7:2]] == a[31:8]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: returns stall-high cycles after the en cycle.
  task automatic model_req(input logic w, input logic [31:0] a, input logic [31:0] d, output int lat);
    int i;
    i = int'(a[7:2]);
    if (model_hit(a)) lat = 1;
    else if (w && !ALLOC) lat = 2;
    else begin
      lat = 1 + ((m_valid[i] && m_dirty[i]) ? 4 : 0) + 4 + 1;
      m_valid[i] = 1'b1;
      m_tag[i]   = a[31:8];
      m_dirty[i] = 1'b0;
    end
    if (w) begin
      model_mem[a] = d;
      if (model_hit(a)) m_dirty[i] = 1'b1;
    end else begin
      last_rd = model_rd(a);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
    end
    model_mem.delete();
    foreach (backing[k]) model_mem[k] = backing[k];
    last_rd = '0;
  endtask

  // Driver tasks
  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(posedge clock); #1;
    bus.en   = 1'b1;
    bus.we   = w;
    bus.addr = a;
    bus.wd   = d;
    @(posedge clock); #1;
    bus.en   = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (bus.stall && n < 1000);
    chk("idle_timeout", {31'b0, bus.stall}, 32'd0);
  endtask

  task automatic single(input logic w, input logic [31:0] a, input logic [31:0] d);
    int lat;
    model_req(w, a, d, lat);
    exp_q.push_back(last_rd);
    lat_q.push_back(lat + 1);
    send(w, a, d);
    wait_idle();
  endtask

  task automatic pair(input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                      input logic w2, input logic [31:0] a2, input logic [31:0] d2);
    int l1, l2;
    model_req(w1, a1, d1, l1);
    model_req(w2, a2, d2, l2);
    exp_q.push_back(last_rd);
    lat_q.push_back(l1 + l2 + 1);
    send(w1, a1, d1);
    send(w2, a2, d2);
    wait_idle();
  endtask

  // Memory responder: inserts wait_cfg wait cycles per word, logs transfers.
  initial begin
    int          waited;
    logic [31:0] ha;
    logic        hw;
    waited = 0;
    ha = '0;
    hw = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_rd    = '0;
    forever begin
      @(negedge clock);
      if (reset_n && bus.mem_en) begin
        if (waited < wait_cfg) begin
          if (waited == 0) begin
            ha = bus.mem_addr;
            hw = bus.mem_we;
          end else begin
            chk("hold_addr", bus.mem_addr, ha);
          end
          waited++;
          wait_total++;
          bus.mem_ready = 1'b0;
        end else begin
          if (waited > 0) begin
            chk("hold_addr", bus.mem_addr, ha);
            chk("hold_we", {31'b0, bus.mem_we}, {31'b0, hw});
          end
          bus.mem_ready = 1'b1;
          if (bus.mem_we) begin
            backing[bus.mem_addr] = bus.mem_wd;
            bus.mem_rd = '0;
          end else begin
            bus.mem_rd = back_rd(bus.mem_addr);
          end
          log_q.push_back('{bus.mem_we, bus.mem_addr, bus.mem_wd});
          waited = 0;
        end
      end else begin
        bus.mem_ready = 1'b0;
        waited = 0;
      end
    end
  end

  // Scoreboard monitor: on each falling edge of stall, compare rd and duration.
  initial begin
    logic        prev;
    int          cnt, w0, el;
    logic [31:0] e;
    prev = 1'b0;
    cnt = 0;
    w0 = 0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        prev = 1'b0;
      end else if (bus.stall) begin
        if (!prev) begin
          cnt = 0;
          w0  = wait_total;
        end
        cnt++;
        prev = 1'b1;
      end else if (prev) begin
        prev = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e  = exp_q.pop_front();
          el = lat_q.pop_front();
          chk("rd", bus.rd, e);
          chk("stall_cycles", cnt, el + (wait_total - w0));
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [31:0] wb_exp [4];
    int          w0, n;
    logic        w1, w2;
    logic [31:0] a1, a2;

    reset_n  = 1'b0;
    bus.en   = 1'b0;
    bus.we   = 1'b0;
    bus.addr = '0;
    bus.wd   = '0;
    model_reset();
    #12;
    chk("rst_stall",    {31'b0, bus.stall},  32'd0);
    chk("rst_rd",       bus.rd,              32'd0);
    chk("rst_mem_en",   {31'b0, bus.mem_en}, 32'd0);
    chk("rst_mem_we",   {31'b0, bus.mem_we}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr,        32'd0);
    chk("rst_mem_wd",   bus.mem_wd,          32'd0);
    chk("rst_state",    {29'b0, dbg_state},  32'd0);
    @(posedge clock); #2;
    reset_n = 1'b1;

    // Cold load: four refill reads at 0x10..0x13
    log_q.delete();
    single(1'b0, 32'h10, 32'h0);
    chk("fill_count", log_q.size(), 32'd4);
    if (log_q.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("fill_addr", log_q[i].addr, 32'h10 + i);
        chk("fill_we", {31'b0, log_q[i].we}, 32'd0);
      end

    // Repeat load hits
    single(1'b0, 32'h12, 32'h0);

    // Store hit: no memory traffic
    log_q.delete();
    single(1'b1, 32'h11, 32'hDEAD_BEEF);
    chk("store_hit_traffic", log_q.size(), 32'd0);

    // Conflict load: write-back of the dirty line, then refill
    log_q.delete();
    wb_exp[0] = 32'hA0;
    wb_exp[1] = 32'hDEAD_BEEF;
    wb_exp[2] = 32'hA2;
    wb_exp[3] = 32'hA3;
    single(1'b0, 32'h111, 32'h0);
    chk("wb_fill_count", log_q.size(), 32'd8);
    if (log_q.size() == 8)
      for (int i = 0; i < 4; i++) begin
        chk("wb_we",     {31'b0, log_q[i].we},     32'd1);
        chk("wb_addr",   log_q[i].addr,            32'h10 + i);
        chk("wb_data",   log_q[i].wd,              wb_exp[i]);
        chk("refill_we", {31'b0, log_q[i + 4].we}, 32'd0);
        chk("refill_addr", log_q[i + 4].addr,      32'h110 + i);
      end

    // Refill with three wait cycles per word
    wait_cfg = 3;
    w0 = wait_total;
    single(1'b0, 32'h180, 32'h0);
    chk("wait_cycles", wait_total - w0, 32'd12);
    wait_cfg = 0;

    // Pending request captured behind a miss
    pair(1'b0, 32'h600, 32'h0, 1'b0, 32'h20, 32'h0);

    // Store miss
    log_q.delete();
    single(1'b1, 32'h40, 32'h1234_5678);
    if (ALLOC) begin
      chk("alloc_count", log_q.size(), 32'd4);
      if (log_q.size() == 4) chk("alloc_addr", log_q[0].addr, 32'h40);
    end else begin
      chk("wthru_count", log_q.size(), 32'd1);
      if (log_q.size() == 1) begin
        chk("wthru_we",   {31'b0, log_q[0].we}, 32'd1);
        chk("wthru_addr", log_q[0].addr,        32'h40);
        chk("wthru_data", log_q[0].wd,          32'h1234_5678);
      end
    end
    single(1'b0, 32'h40, 32'h0);

    // Reset during refill word 2
    wait_cfg = 3;
    send(1'b0, 32'h340, 32'h0);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(bus.mem_en && !bus.mem_we && bus.mem_addr == 32'h342) && n < 200);
    chk("reach_word2", {31'b0, bus.mem_en}, 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort_mem_en", {31'b0, bus.mem_en}, 32'd0);
    chk("abort_stall",  {31'b0, bus.stall},  32'd0);
    exp_q.delete();
    lat_q.delete();
    @(negedge clock);
    @(posedge clock); #2;
    reset_n  = 1'b1;
    wait_cfg = 0;
    model_reset();
    chk("abort_rd",    bus.rd,             32'd0);
    chk("abort_state", {29'b0, dbg_state}, 32'd0);
    log_q.delete();
    single(1'b0, 32'h340, 32'h0);
    chk("refetch_count", log_q.size(), 32'd4);
    if (log_q.size() == 4)
      for (int i = 0; i < 4; i++) chk("refetch_addr", log_q[i].addr, 32'h340 + i);

    // Randomized traffic over a small conflicting address pool
    for (int k = 0; k < 300; k++) begin
      wait_cfg = $urandom_range(0, 2);
      w1 = 1'($urandom_range(0, 1));
      a1 = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      if (!w1 && !model_hit(a1) && $urandom_range(0, 3) == 0) begin
        w2 = 1'($urandom_range(0, 1));
        a2 = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
        pair(w1, a1, $urandom, w2, a2, $urandom);
      end else begin
        single(w1, a1, $urandom);
      end
    end
    wait_cfg = 0;

    repeat (3) @(negedge clock);
    chk("leftover_expected", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
